disp_sched: RTL and testbench
=============================

# disp_sched

Sequencing controller for the four-digit seven-segment display. It arbitrates between two requesters: a numeric BCD value and an eight-code status message scrolled right-to-left. It produces four 4-bit display codes, each driving one `seven_seg` decoder instance. Codes use the decoder's set:
- 0–9: digits
- A: off
- B: dash
- C: H
- D: L
- E: E
- F: P

## Interface
Parameters:
- `TICK_DIV`, 25000000, clock cycles per scroll/blink tick; must be ≥ 2.

Ports:
- `clk` in 1: system clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `num_req` in 1: numeric display request; held high with `num_bcd` stable until `num_ack`.
- `num_bcd` in 16: four BCD digits; [15:12] is the leftmost digit.
- `num_ack` out 1: one-cycle accept pulse; `num_bcd` is captured in this cycle.
- `msg_req` in 1: message request; held high with `msg_code` stable until `msg_ack`.
- `msg_code` in 32: eight display codes; [31:28] is shown first.
- `msg_ack` out 1: one-cycle accept pulse; `msg_code` is captured in this cycle.
- `disp_code` out 16: codes to the four decoders; [15:12] is the leftmost digit.
- `busy` out 1: high while in SCROLL.
- `num_err` out 1: high while the latched number contains a digit > 9.

## Operation
States: BLANK (reset state), SHOW_NUM, SCROLL.

**BLANK**
- `disp_code` = 16'hAAAA.
- Arbitration: if `msg_req`, ack the message and go to SCROLL; else if `num_req`, ack the number and go to SHOW_NUM.

**SHOW_NUM**
- `disp_code` = the latched number, with any digit > 9 replaced by 4'hB.
- Arbitration is the same as BLANK; a new `num_req` re-latches and stays in SHOW_NUM.

**SCROLL**
- Window starts at 16'hAAAA.
- Each tick: window <= {window[11:0], next}. `next` takes the 8 message codes in order, then 4 × 4'hA.
- After 12 ticks, go to SHOW_NUM if a number has ever been latched since reset; otherwise go to BLANK.
- `num_req` is accepted during SCROLL: the number register updates, but the display is not interrupted.
- `msg_req` is not accepted during SCROLL; it waits for the exit.

**Arbitration and handshake rules**
- The message requester has fixed priority over the number requester.
- In SCROLL, `num_ack` may pulse; `msg_ack` stays low.
- A request is not re-sampled in the cycle its ack is high, and never in the cycle after. No double accept occurs even if the requester drops `req` late by one cycle.

**Tick and error flag**
- Tick: a counter 0..`TICK_DIV`−1 pulses when it reaches `TICK_DIV`−1. The counter clears on entry to SCROLL.
- `num_err` is updated whenever a number is latched.

**Reset**
- `rst` asserted mid-scroll aborts immediately.
- All outputs after reset: `disp_code` = 16'hAAAA, `num_ack` = 0, `msg_ack` = 0, `busy` = 0, `num_err` = 0.
- After reset, the number-valid flag and the tick counter are 0.

## Timing
- Acks are registered: `ack` is high in cycle N+1 for a `req` sampled high at edge N with grant. Data is captured at the same edge.
- `disp_code` reflects a new number in the cycle after `num_ack`, i.e. 2 cycles after `req` is sampled.
- `busy` rises together with `msg_ack`.
- First scroll shift occurs `TICK_DIV` cycles after `msg_ack`; the last shift at 12 × `TICK_DIV`.
- The exit transition happens on the cycle after the 12th tick. `busy` falls then.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
`DISP_BLINK_EN`
- **Defined:** adds input `blink` (1 bit). While in SHOW_NUM with `blink` high, `disp_code` toggles between the number and 16'hAAAA on every tick. The first tick after `blink` rises shows 16'hAAAA. The tick counter runs freely in SHOW_NUM.
- **Undefined:** no `blink` port; SHOW_NUM is steady and the counter is held at 0 outside SCROLL.

## Structure
- Package `disp_pkg`:
  - code constants `CODE_OFF` = 4'hA, `CODE_DASH` = 4'hB, `CODE_H` = 4'hC, `CODE_L` = 4'hD, `CODE_E` = 4'hE, `CODE_P` = 4'hF.
  - the state enum: BLANK, SHOW_NUM, SCROLL.
  - the scroll length constant `SCROLL_STEPS` = 12.
- Sub-module `tick_gen`: parameterised by `TICK_DIV`, with a synchronous `clr` input and a `tick` output pulse. It is instantiated once.
- The four `seven_seg` decoders live in the parent, not in `disp_sched`.

## Test plan
All scenarios use `TICK_DIV` = 4.
- Reset, then idle 20 cycles → `disp_code` = AAAA; `busy`, acks and `num_err` all 0.
- `num_req` with num_bcd = 16'h1234 → `num_ack` one cycle later for exactly 1 cycle; next cycle `disp_code` = 1234 and `num_err` = 0. A held-late `req` produces no second ack.
- num_bcd = 16'h12C4 → `disp_code` = 12B4, `num_err` = 1.
- `msg_code` = 32'hCEDDF0AA after a number 0042 is shown → `disp_code` sequence AAAC, AACE, ACED, …, then AAAA. The exit returns to 0042 after 12 ticks (48 cycles); `busy` covers exactly that span.
- `num_req` (5678) and `msg_req` raised together in BLANK → message acked first. `num_ack` does not wait for the scroll: it pulses while the message is still scrolling, and after the scroll the display shows 5678. `msg_req` raised during the scroll is acked only after exit.
- `rst` pulsed at tick 5 of a scroll → `disp_code` = AAAA asynchronously; state is BLANK with the number-valid flag cleared.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared constants, state encoding and digit helpers for the seven-segment display sequencer.
package disp_pkg;

  localparam logic [3:0] CODE_OFF  = 4'hA;
  localparam logic [3:0] CODE_DASH = 4'hB;
  localparam logic [3:0] CODE_H    = 4'hC;
  localparam logic [3:0] CODE_L    = 4'hD;
  localparam logic [3:0] CODE_E    = 4'hE;
  localparam logic [3:0] CODE_P    = 4'hF;

  localparam logic [15:0] DISP_BLANK   = {4{CODE_OFF}};
  localparam int          SCROLL_STEPS = 12;

  typedef enum logic [1:0] {
    BLANK,
    SHOW_NUM,
    SCROLL
  } state_e;

  // Non-decimal digits are shown as a dash so a corrupt value is visible but harmless.
  function automatic logic [15:0] num_to_disp(input logic [15:0] bcd);
    logic [15:0] res;
    res = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] > 4'd9) res[4*i +: 4] = CODE_DASH;
    end
    return res;
  endfunction

  function automatic logic has_bad_digit(input logic [15:0] bcd);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running divider producing a one-cycle tick every TICK_DIV cycles, with synchronous clear.
module tick_gen #(
  parameter int TICK_DIV = 25000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CNT_W'(TICK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/disp_sched.sv
// Four-digit display sequencer arbitrating a BCD number against a scrolled 8-code message.
// Optional DISP_BLINK_EN adds a blink input that flashes the number on every tick.
module disp_sched
  import disp_pkg::*;
#(
  parameter int TICK_DIV = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        num_req,
  input  logic [15:0] num_bcd,
  output logic        num_ack,
  input  logic        msg_req,
  input  logic [31:0] msg_code,
  output logic        msg_ack,
  output logic [15:0] disp_code,
  output logic        busy,
  output logic        num_err
`ifdef DISP_BLINK_EN
  ,
  input  logic        blink
`endif
);

  state_e      state_q, state_d;
  logic [15:0] num_q, num_d;
  logic        nvalid_q, nvalid_d;
  logic        err_q, err_d;
  logic [15:0] win_q, win_d;
  logic [31:0] msg_q, msg_d;
  logic [3:0]  step_q, step_d;
  logic        num_ack_q, num_ack_d, num_hold_q;
  logic        msg_ack_q, msg_ack_d, msg_hold_q;
  logic        busy_q;
  logic [15:0] disp_q, disp_d;
  logic        tick, tick_clr;
  logic        num_ok, msg_ok, num_grant, msg_grant;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (tick_clr),
    .tick (tick)
  );

  // A requester is blind while its ack is high and for one cycle after, so a late drop cannot re-trigger.
  assign num_ok = num_req && !num_ack_q && !num_hold_q;
  assign msg_ok = msg_req && !msg_ack_q && !msg_hold_q;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d   = state_q;
    num_d     = num_q;
    nvalid_d  = nvalid_q;
    err_d     = err_q;
    win_d     = win_q;
    msg_d     = msg_q;
    step_d    = step_q;
    num_ack_d = 1'b0;
    msg_ack_d = 1'b0;
    num_grant = 1'b0;
    msg_grant = 1'b0;

    case (state_q)
      BLANK, SHOW_NUM: begin
        if (msg_ok)      msg_grant = 1'b1;
        else if (num_ok) num_grant = 1'b1;
      end
      SCROLL:  num_grant = num_ok;
      default: state_d = BLANK;
    endcase

    if (num_grant) begin
      num_d     = num_bcd;
      nvalid_d  = 1'b1;
      err_d     = has_bad_digit(num_bcd);
      num_ack_d = 1'b1;
      if (state_q != SCROLL) state_d = SHOW_NUM;
    end

    if (msg_grant) begin
      msg_ack_d = 1'b1;
      msg_d     = msg_code;
      win_d     = DISP_BLANK;
      step_d    = '0;
      state_d   = SCROLL;
    end

    if (state_q == SCROLL && tick) begin
      win_d  = {win_q[11:0], msg_q[31:28]};
      msg_d  = {msg_q[27:0], CODE_OFF};
      step_d = step_q + 4'd1;
      if (step_q == 4'(SCROLL_STEPS - 1)) state_d = nvalid_d ? SHOW_NUM : BLANK;
    end
  end

`ifdef DISP_BLINK_EN
  logic blink_ph_q, blink_ph_d;

  // Phase restarts low whenever blinking stops, so the first tick after blink rises blanks.
  assign blink_ph_d = (state_q == SHOW_NUM && blink) ? (blink_ph_q ^ tick) : 1'b0;
  assign tick_clr   = (state_q == BLANK) || (state_q != SCROLL && state_d == SCROLL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) blink_ph_q <= 1'b0;
    else     blink_ph_q <= blink_ph_d;
  end

  always_comb begin
    disp_d = DISP_BLANK;
    if (state_d == SCROLL)                       disp_d = win_d;
    else if (state_q == SHOW_NUM && !(blink && blink_ph_q)) disp_d = num_to_disp(num_q);
  end
`else
  assign tick_clr = (state_q != SCROLL);

  always_comb begin
    disp_d = DISP_BLANK;
    if (state_d == SCROLL)          disp_d = win_d;
    else if (state_q == SHOW_NUM)   disp_d = num_to_disp(num_q);
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= BLANK;
      num_q      <= '0;
      nvalid_q   <= 1'b0;
      err_q      <= 1'b0;
      win_q      <= DISP_BLANK;
      msg_q      <= '0;
      step_q     <= '0;
      num_ack_q  <= 1'b0;
      num_hold_q <= 1'b0;
      msg_ack_q  <= 1'b0;
      msg_hold_q <= 1'b0;
      busy_q     <= 1'b0;
      disp_q     <= DISP_BLANK;
    end else begin
      state_q    <= state_d;
      num_q      <= num_d;
      nvalid_q   <= nvalid_d;
      err_q      <= err_d;
      win_q      <= win_d;
      msg_q      <= msg_d;
      step_q     <= step_d;
      num_ack_q  <= num_ack_d;
      num_hold_q <= num_ack_q;
      msg_ack_q  <= msg_ack_d;
      msg_hold_q <= msg_ack_q;
      busy_q     <= (state_d == SCROLL);
      disp_q     <= disp_d;
    end
  end

  assign num_ack   = num_ack_q;
  assign msg_ack   = msg_ack_q;
  assign busy      = busy_q;
  assign num_err   = err_q;
  assign disp_code = disp_q;

endmodule

// File: tb/tb_disp_sched.sv
// Directed self-checking bench for disp_sched with TICK_DIV = 4.
module tb_disp_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        num_req = 1'b0;
  logic [15:0] num_bcd = '0;
  logic        msg_req = 1'b0;
  logic [31:0] msg_code = '0;
  logic        num_ack, msg_ack, busy, num_err;
  logic [15:0] disp_code;

  int vectors = 0;
  int miscompares = 0;

  // Window contents for message CEDDF0AA after 0..12 shifts.
  logic [15:0] win_exp [13] = '{16'hAAAA, 16'hAAAC, 16'hAACE, 16'hACED, 16'hCEDD,
                                16'hEDDF, 16'hDDF0, 16'hDF0A, 16'hF0AA, 16'h0AAA,
                                16'hAAAA, 16'hAAAA, 16'hAAAA};

  disp_sched #(.TICK_DIV(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .num_req   (num_req),
    .num_bcd   (num_bcd),
    .num_ack   (num_ack),
    .msg_req   (msg_req),
    .msg_code  (msg_code),
    .msg_ack   (msg_ack),
    .disp_code (disp_code),
    .busy      (busy),
    .num_err   (num_err)
`ifdef DISP_BLINK_EN
    ,
    .blink     (1'b0)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Follows one CEDDF0AA scroll from its grant edge; k counts cycles after that edge.
  task automatic scroll_watch(input logic [15:0] after_disp, input bit num_pend, input int remsg_k);
    logic [15:0] exp_disp;
    for (int k = 1; k <= 50; k++) begin
      cyc(1);
      if (k == 50) exp_disp = (remsg_k > 0) ? 16'hAAAA : after_disp;
      else         exp_disp = win_exp[(k - 1) / 4];
      check("scroll_disp", disp_code, exp_disp);
      check("scroll_busy", busy, (k <= 48) || (k == 50 && remsg_k > 0));
      check("scroll_msg_ack", msg_ack, (k == 1) || (k == 50 && remsg_k > 0));
      check("scroll_num_ack", num_ack, num_pend && k == 2);
      if (k == 1) msg_req = 1'b0;
      if (k == 2) num_req = 1'b0;
      if (k == remsg_k) begin
        msg_req  = 1'b1;
        msg_code = 32'h12345678;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Asynchronous reset takes effect before any clock edge.
    #2 rst = 1'b1;
    #1;
    check("rst_async_disp", disp_code, 16'hAAAA);
    check("rst_async_busy", busy, 1'b0);
    cyc(2);
    rst = 1'b0;
    cyc(20);
    check("idle_disp", disp_code, 16'hAAAA);
    check("idle_busy", busy, 1'b0);
    check("idle_num_ack", num_ack, 1'b0);
    check("idle_msg_ack", msg_ack, 1'b0);
    check("idle_num_err", num_err, 1'b0);

    // Number 1234 with the requester dropping req one cycle late.
    num_bcd = 16'h1234;
    num_req = 1'b1;
    cyc(1);
    check("n1234_ack", num_ack, 1'b1);
    check("n1234_disp_pre", disp_code, 16'hAAAA);
    cyc(1);
    check("n1234_ack_once", num_ack, 1'b0);
    check("n1234_disp", disp_code, 16'h1234);
    check("n1234_err", num_err, 1'b0);
    cyc(1);
    check("n1234_late_ack", num_ack, 1'b0);
    num_req = 1'b0;
    cyc(1);
    check("n1234_late_ack2", num_ack, 1'b0);
    cyc(2);

    // Invalid digit is dashed and flagged.
    num_bcd = 16'h12C4;
    num_req = 1'b1;
    cyc(1);
    check("n12C4_ack", num_ack, 1'b1);
    num_req = 1'b0;
    cyc(1);
    check("n12C4_disp", disp_code, 16'h12B4);
    check("n12C4_err", num_err, 1'b1);
    cyc(2);

    num_bcd = 16'h0042;
    num_req = 1'b1;
    cyc(1);
    check("n0042_ack", num_ack, 1'b1);
    num_req = 1'b0;
    cyc(1);
    check("n0042_disp", disp_code, 16'h0042);
    check("n0042_err", num_err, 1'b0);
    cyc(2);

    // Scroll over a shown number, returning to it afterwards.
    msg_code = 32'hCEDDF0AA;
    msg_req  = 1'b1;
    scroll_watch(16'h0042, 1'b0, 0);
    cyc(2);

    // Back to BLANK, then simultaneous requests: message wins, number acked mid-scroll.
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(1);
    check("blank_disp", disp_code, 16'hAAAA);
    num_bcd  = 16'h5678;
    num_req  = 1'b1;
    msg_code = 32'hCEDDF0AA;
    msg_req  = 1'b1;
    scroll_watch(16'h5678, 1'b1, 0);
    check("n5678_err", num_err, 1'b0);
    cyc(2);

    // Message raised mid-scroll waits for the exit, then starts a new scroll.
    msg_code = 32'hCEDDF0AA;
    msg_req  = 1'b1;
    scroll_watch(16'h5678, 1'b0, 10);
    msg_req = 1'b0;
    cyc(20);
    check("m2_tick5_disp", disp_code, 16'h2345);
    check("m2_tick5_busy", busy, 1'b1);

    // Reset mid-scroll aborts immediately and forgets the number.
    #2 rst = 1'b1;
    #1;
    check("abort_disp", disp_code, 16'hAAAA);
    check("abort_busy", busy, 1'b0);
    check("abort_msg_ack", msg_ack, 1'b0);
    check("abort_num_ack", num_ack, 1'b0);
    cyc(1);
    rst = 1'b0;
    cyc(1);
    check("post_abort_disp", disp_code, 16'hAAAA);
    check("post_abort_err", num_err, 1'b0);
    msg_code = 32'hCEDDF0AA;
    msg_req  = 1'b1;
    scroll_watch(16'hAAAA, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
